iram_ext_bridge: RTL and testbench
==================================

IRAM_EXT_BRIDGE -- requirements
Module: iram_ext_bridge

Interface
REQ-001 SHALL have parameter IRAM_BASE, default 32'h8000_0000, byte base address of IRAM window.
REQ-002 SHALL have parameter IRAM_SIZE, default 32'h0001_0000, window size in bytes, power of two.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, ISSUE-state cycle limit; used only with timeout compiled in.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk_i, input, 1, sole clock, posedge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port s_req_valid, input, 1, upstream request valid.
REQ-008 SHALL have port s_req_ready, output, 1, bridge accepts request.
REQ-009 SHALL have port s_req_addr, input, 32, byte address.
REQ-010 SHALL have port s_req_wdata, input, 32, write data.
REQ-011 SHALL have port s_req_we, input, 1, 1 = write.
REQ-012 SHALL have port s_req_strb, input, 4, byte enables.
REQ-013 SHALL have port s_rsp_valid, output, 1, response valid.
REQ-014 SHALL have port s_rsp_ready, input, 1, upstream accepts response.
REQ-015 SHALL have port s_rsp_rdata, output, 32, read data; 0 on error or write.
REQ-016 SHALL have port s_rsp_error, output, 1, access error.
REQ-017 SHALL have port ext_iram_req, output, SOPHON_PKG::lsu_req_t, request to IRAM arbiter external channel.
REQ-018 SHALL have port ext_iram_ack, input, SOPHON_PKG::lsu_ack_t, arbiter acknowledge.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, RESP; at most one transaction outstanding.
REQ-020 s_req_ready SHALL be 1 only in IDLE, combinational from state.
REQ-021 On s_req_valid&s_req_ready, addr/wdata/we/strb SHALL be registered; in-range addr (IRAM_BASE <= addr < IRAM_BASE+IRAM_SIZE, no 32-bit overflow) -> ISSUE, else -> RESP with error=1, rdata=0, no ext request.
REQ-022 In ISSUE, ext_iram_req.req SHALL be 1 (registered) with addr/wdata/we/strb held stable every cycle.
REQ-023 On ext_iram_ack.ack=1 in ISSUE: capture rdata (forced 0 if we=1) and error; req SHALL be 0 from next cycle; -> RESP.
REQ-024 ext_iram_req.req SHALL be 0 in IDLE and RESP, guaranteeing >=1 low cycle between consecutive requests so the arbiter's request counter clears.
REQ-025 In RESP, s_rsp_valid=1 with stable rdata/error; on s_rsp_ready=1 -> IDLE; new request accepted no earlier than the following cycle.
REQ-026 Minimum latency, in-range access, arbiter ack 2 cycles after req rise: handshake cycle 0, req cycles 1-3, ack seen cycle 3, s_rsp_valid cycle 4.
REQ-027 ext_iram_ack.ack outside ISSUE SHALL be ignored.

Reset
REQ-028 On rst_i=1: state IDLE, ext_iram_req all fields 0, s_rsp_valid=0, s_rsp_rdata=0, s_rsp_error=0, registers cleared, asynchronously.
REQ-029 Reset during ISSUE or RESP SHALL abort the transaction with no response; a late ack after reset is ignored.

Configuration
REQ-030 With IRAM_BRIDGE_TIMEOUT_EN defined, an ISSUE-cycle counter SHALL force req=0 and go to RESP with error=1, rdata=0 after TIMEOUT_CYCLES cycles without ack; ack and timeout in the same cycle -> ack wins.
REQ-031 Without IRAM_BRIDGE_TIMEOUT_EN, no counter SHALL exist and ISSUE waits indefinitely for ack.

Structure
REQ-032 State enum and IRAM_BASE/IRAM_SIZE default constants SHALL live in SOPHON_PKG beside lsu_req_t/lsu_ack_t.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 Read 0x8000_0010, ack 2 cycles after req rise, rdata 0xDEADBEEF -> s_rsp_valid cycle 4, rdata 0xDEADBEEF, error 0.
REQ-035 Write 0x8000_0004, wdata 0x1234_5678, strb 4'b0011 -> req fields stable until ack, rsp rdata 0, error 0.
REQ-036 Read 0x9000_0000 -> no ext req ever, rsp error 1 the cycle after handshake.
REQ-037 Back-to-back requests, s_rsp_ready tied 1 -> req low >=1 cycle between transactions, both responses correct.
REQ-038 s_rsp_ready held 0 for 5 cycles -> rsp held stable, s_req_ready 0 throughout.
REQ-039 IRAM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never -> req drops after 16 cycles, rsp error 1; rst_i mid-ISSUE -> req 0 immediately, no response.

Source files
------------

// File: rtl/SOPHON_PKG.sv
// Shared LSU/IRAM channel types plus the IRAM bridge state encoding and window defaults.
// Also hosts the address-window helper used by iram_ext_bridge.
package SOPHON_PKG;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  strb;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        error;
    } lsu_ack_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } iram_bridge_state_e;

    localparam logic [31:0] IRAM_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] IRAM_SIZE_DEFAULT = 32'h0001_0000;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic iram_addr_in_window(input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/iram_ext_bridge.sv
// Single-outstanding bridge from a valid/ready request/response port onto the IRAM arbiter external channel.
// Optional ISSUE timeout is compiled in with `define IRAM_BRIDGE_TIMEOUT_EN.
module iram_ext_bridge
    import SOPHON_PKG::*;
#(
    parameter logic [31:0] IRAM_BASE      = IRAM_BASE_DEFAULT,
    parameter logic [31:0] IRAM_SIZE      = IRAM_SIZE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               s_req_valid,
    output logic               s_req_ready,
    input  logic [31:0]        s_req_addr,
    input  logic [31:0]        s_req_wdata,
    input  logic               s_req_we,
    input  logic [3:0]         s_req_strb,
    output logic               s_rsp_valid,
    input  logic               s_rsp_ready,
    output logic [31:0]        s_rsp_rdata,
    output logic               s_rsp_error,
    output lsu_req_t           ext_iram_req,
    input  lsu_ack_t           ext_iram_ack,
    output iram_bridge_state_e dbg_state_o
);

    // Handshakes: a request transfers on a cycle where s_req_valid && s_req_ready,
    // a response on s_rsp_valid && s_rsp_ready; valid never depends on ready.

    iram_bridge_state_e state_q, state_d;
    lsu_req_t           req_q, req_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_error_q, rsp_error_d;
    logic               tmo_expired;

`ifdef IRAM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is zero on ISSUE entry and holds k-1 in the k-th ISSUE cycle.
    always_comb begin
        tmo_cnt_d   = '0;
        tmo_expired = 1'b0;
        if (state_q == ISSUE) begin
            tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
            tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // Timeout logic is absent in this build; ISSUE waits for ack indefinitely.
    localparam int unsigned unused_tmo_cycles = TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        s_req_ready = (state_q == IDLE);
        s_rsp_valid = (state_q == RESP);

        case (state_q)
            IDLE: begin
                if (s_req_valid) begin
                    req_d.addr  = s_req_addr;
                    req_d.wdata = s_req_wdata;
                    req_d.we    = s_req_we;
                    req_d.strb  = s_req_strb;
                    if (iram_addr_in_window(s_req_addr, IRAM_BASE, IRAM_SIZE)) begin
                        req_d.req = 1'b1;
                        state_d   = ISSUE;
                    end else begin
                        req_d.req   = 1'b0;
                        rsp_rdata_d = '0;
                        rsp_error_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ISSUE: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (ext_iram_ack.ack) begin
                    req_d.req   = 1'b0;
                    rsp_rdata_d = req_q.we ? 32'h0 : ext_iram_ack.rdata;
                    rsp_error_d = ext_iram_ack.error;
                    state_d     = RESP;
                end else if (tmo_expired) begin
                    req_d.req   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (s_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d.req = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign ext_iram_req = req_q;
    assign s_rsp_rdata  = rsp_rdata_q;
    assign s_rsp_error  = rsp_error_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_iram_ext_bridge.sv
// Randomized self-checking bench for iram_ext_bridge; the bench plays the IRAM arbiter.
// Expected responses come from a window/ack model and are queued in exp_q.
module tb_iram_ext_bridge;
    import SOPHON_PKG::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;
    localparam int          TMO  = 16;

    logic               clk;
    logic               rst;
    logic               s_req_valid;
    logic               s_req_ready;
    logic [31:0]        s_req_addr;
    logic [31:0]        s_req_wdata;
    logic               s_req_we;
    logic [3:0]         s_req_strb;
    logic               s_rsp_valid;
    logic               s_rsp_ready;
    logic [31:0]        s_rsp_rdata;
    logic               s_rsp_error;
    lsu_req_t           ext_req;
    lsu_ack_t           ext_ack;
    iram_bridge_state_e dbg_state;

    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    iram_ext_bridge #(
        .IRAM_BASE      (BASE),
        .IRAM_SIZE      (SIZE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_addr   (s_req_addr),
        .s_req_wdata  (s_req_wdata),
        .s_req_we     (s_req_we),
        .s_req_strb   (s_req_strb),
        .s_rsp_valid  (s_rsp_valid),
        .s_rsp_ready  (s_rsp_ready),
        .s_rsp_rdata  (s_rsp_rdata),
        .s_rsp_error  (s_rsp_error),
        .ext_iram_req (ext_req),
        .ext_iram_ack (ext_ack),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: is the byte address inside [BASE, BASE+SIZE)?
    function automatic logic model_in_window(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + longint'(SIZE));
    endfunction

    // One full transaction. ack_dly = cycles after req rise before ack (-1: never ack).
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                           input logic [3:0] strb, input int ack_dly, input logic [31:0] ack_rdata,
                           input logic ack_err, input int hold);
        logic [32:0] exp;
        logic [32:0] got;
        int          n_issue;
        @(negedge clk);
        check("req_ready_idle", s_req_ready, 1);
        check("ext_req_low_idle", ext_req.req, 0);
        check("rsp_valid_idle", s_rsp_valid, 0);
        s_req_valid = 1'b1;
        s_req_addr  = addr;
        s_req_wdata = wdata;
        s_req_we    = we;
        s_req_strb  = strb;
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        s_req_addr  = $urandom;
        s_req_wdata = $urandom;
        s_req_we    = 1'($urandom);
        s_req_strb  = 4'($urandom);
        if (model_in_window(addr)) begin
            if (ack_dly < 0) begin
                exp     = {1'b1, 32'h0};
                n_issue = TMO;
            end else begin
                exp     = {ack_err, (we ? 32'h0 : ack_rdata)};
                n_issue = ack_dly + 1;
            end
            exp_q.push_back(exp);
            for (int c = 0; c < n_issue; c++) begin
                @(negedge clk);
                check("issue_req", ext_req.req, 1);
                check("issue_addr", ext_req.addr, addr);
                check("issue_wdata", ext_req.wdata, wdata);
                check("issue_we", ext_req.we, we);
                check("issue_strb", ext_req.strb, strb);
                check("issue_rsp_valid", s_rsp_valid, 0);
                check("issue_req_ready", s_req_ready, 0);
                if (ack_dly >= 0 && c == ack_dly) begin
                    ext_ack.ack   = 1'b1;
                    ext_ack.rdata = ack_rdata;
                    ext_ack.error = ack_err;
                end
                @(posedge clk);
                #1;
                ext_ack.ack   = 1'b0;
                ext_ack.rdata = $urandom;
                ext_ack.error = 1'($urandom);
            end
        end else begin
            exp_q.push_back({1'b1, 32'h0});
        end
        exp = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            got = {s_rsp_error, s_rsp_rdata};
            check("rsp_valid", s_rsp_valid, 1);
            check(h == 0 ? "rsp_data" : "rsp_data_held", got, exp);
            check("rsp_ext_req_low", ext_req.req, 0);
            check("rsp_req_ready", s_req_ready, 0);
            if (h == hold) begin
                s_rsp_ready = 1'b1;
            end else begin
                ext_ack.ack   = 1'($urandom);
                ext_ack.rdata = $urandom;
                ext_ack.error = 1'($urandom);
            end
            @(posedge clk);
            #1;
            s_rsp_ready = 1'b0;
            ext_ack.ack = 1'b0;
        end
    endtask

    // Reset asserted mid-ISSUE, then a late ack that must be ignored.
    task automatic reset_mid_issue();
        @(negedge clk);
        s_req_valid = 1'b1;
        s_req_addr  = BASE + 32'h20;
        s_req_we    = 1'b0;
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_req", ext_req.req, 1);
        rst = 1'b1;
        #1;
        check("rst_req_low", ext_req.req, 0);
        check("rst_addr_clr", ext_req.addr, 0);
        check("rst_rsp_valid", s_rsp_valid, 0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst           = 1'b0;
        ext_ack.ack   = 1'b1;
        ext_ack.rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        ext_ack.ack = 1'b0;
        @(negedge clk);
        check("late_ack_no_rsp", s_rsp_valid, 0);
        check("late_ack_req_low", ext_req.req, 0);
        check("late_ack_idle", s_req_ready, 1);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        s_req_valid = 1'b0;
        s_req_addr  = '0;
        s_req_wdata = '0;
        s_req_we    = 1'b0;
        s_req_strb  = '0;
        s_rsp_ready = 1'b0;
        ext_ack     = '0;
        #1;
        check("reset_req", ext_req.req, 0);
        check("reset_addr", ext_req.addr, 0);
        check("reset_wdata", ext_req.wdata, 0);
        check("reset_rsp_valid", s_rsp_valid, 0);
        check("reset_rsp_rdata", s_rsp_rdata, 0);
        check("reset_rsp_error", s_rsp_error, 0);
        check("reset_state", dbg_state, IDLE);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // directed cases
        run_txn(32'h8000_0010, 32'h0, 1'b0, 4'hF, 2, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(32'h8000_0004, 32'h1234_5678, 1'b1, 4'b0011, 2, 32'hFFFF_FFFF, 1'b0, 0);
        run_txn(32'h9000_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 1'b0, 0);
        run_txn(32'h8000_0100, 32'h0, 1'b0, 4'hF, 0, 32'h0BAD_F00D, 1'b1, 5);
        run_txn(BASE + SIZE - 32'h4, 32'h0, 1'b0, 4'hF, 1, 32'hA5A5_5A5A, 1'b0, 0);
        run_txn(BASE + SIZE, 32'h0, 1'b0, 4'hF, 1, 32'h1111_1111, 1'b0, 0);
        run_txn(BASE - 32'h4, 32'h0, 1'b1, 4'hF, 1, 32'h2222_2222, 1'b0, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + ($urandom_range(0, int'(SIZE / 4) - 1) << 2);
                3:       a = BASE + SIZE - 32'h4;
                4:       a = BASE + SIZE + ($urandom_range(0, 15) << 2);
                default: a = $urandom;
            endcase
            run_txn(a, $urandom, 1'($urandom), 4'($urandom), $urandom_range(0, 3),
                    $urandom, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

`ifdef IRAM_BRIDGE_TIMEOUT_EN
        run_txn(32'h8000_0040, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, 1);
`endif

        reset_mid_issue();
        run_txn(32'h8000_0008, 32'h0, 1'b0, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
